axi_lite_arb_2to1: RTL



---
 rtl/axi_lite_arb_2to1_if.sv | 44 ++++
 rtl/axi_lite_arb_2to1.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/axi_lite_arb_2to1_if.sv
// AXI4-Lite bundle shared by the 2:1 arbiter's upstream and downstream ports.
// master drives requests (AW/W/AR valid, B/R ready); slave drives the responses.
interface axi_lite_arb_2to1_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] awaddr;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/axi_lite_arb_2to1.sv
// Two-to-one AXI4-Lite arbiter: independent round-robin write and read paths,
// one outstanding transaction per path, pure combinational routing of payload.
module axi_lite_arb_2to1 #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input logic                  clk,
  input logic                  rst,
  axi_lite_arb_2to1_if.slave   s0,
  axi_lite_arb_2to1_if.slave   s1,
  axi_lite_arb_2to1_if.master  m
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {W_IDLE, W_FWD, W_RESP} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_FWD, R_DATA} rstate_t;

  wstate_t r_wstate;
  rstate_t r_rstate;
  logic    r_wgnt;
  logic    r_wr_last;
  logic    r_aw_done;
  logic    r_w_done;
  logic    r_rgnt;
  logic    r_rd_last;

  logic                  w_wfwd, w_wresp, w_rfwd, w_rdat;
  logic [ADDR_WIDTH-1:0] w_awaddr, w_araddr;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [STRB_WIDTH-1:0] w_wstrb;
  logic                  w_s_awvalid, w_s_wvalid, w_s_bready, w_s_arvalid, w_s_rready;
  logic                  w_m_awvalid, w_m_wvalid, w_m_bready, w_m_arvalid, w_m_rready;
  logic                  w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;

  assign w_wfwd  = (r_wstate == W_FWD);
  assign w_wresp = (r_wstate == W_RESP);
  assign w_rfwd  = (r_rstate == R_FWD);
  assign w_rdat  = (r_rstate == R_DATA);

  // Upstream selection by the registered grants
  assign w_awaddr    = r_wgnt ? s1.awaddr  : s0.awaddr;
  assign w_wdata     = r_wgnt ? s1.wdata   : s0.wdata;
  assign w_wstrb     = r_wgnt ? s1.wstrb   : s0.wstrb;
  assign w_s_awvalid = r_wgnt ? s1.awvalid : s0.awvalid;
  assign w_s_wvalid  = r_wgnt ? s1.wvalid  : s0.wvalid;
  assign w_s_bready  = r_wgnt ? s1.bready  : s0.bready;
  assign w_araddr    = r_rgnt ? s1.araddr  : s0.araddr;
  assign w_s_arvalid = r_rgnt ? s1.arvalid : s0.arvalid;
  assign w_s_rready  = r_rgnt ? s1.rready  : s0.rready;

  // AW and W valids are masked once their own handshake has happened
  assign w_m_awvalid = w_wfwd & ~r_aw_done & w_s_awvalid;
  assign w_m_wvalid  = w_wfwd & ~r_w_done  & w_s_wvalid;
  assign w_m_bready  = w_wresp & w_s_bready;
  assign w_m_arvalid = w_rfwd & w_s_arvalid;
  assign w_m_rready  = w_rdat & w_s_rready;

  assign w_aw_hs = w_m_awvalid & m.awready;
  assign w_w_hs  = w_m_wvalid  & m.wready;
  assign w_b_hs  = m.bvalid    & w_m_bready;
  assign w_ar_hs = w_m_arvalid & m.arready;
  assign w_r_hs  = m.rvalid    & w_m_rready;

  assign m.awaddr  = w_awaddr;
  assign m.awprot  = r_wgnt ? s1.awprot : s0.awprot;
  assign m.awvalid = w_m_awvalid;
  assign m.wdata   = w_wdata;
  assign m.wstrb   = w_wstrb;
  assign m.wvalid  = w_m_wvalid;
  assign m.bready  = w_m_bready;
  assign m.araddr  = w_araddr;
  assign m.arprot  = r_rgnt ? s1.arprot : s0.arprot;
  assign m.arvalid = w_m_arvalid;
  assign m.rready  = w_m_rready;

  assign s0.awready = w_wfwd & ~r_wgnt & ~r_aw_done & m.awready;
  assign s1.awready = w_wfwd &  r_wgnt & ~r_aw_done & m.awready;
  assign s0.wready  = w_wfwd & ~r_wgnt & ~r_w_done & m.wready;
  assign s1.wready  = w_wfwd &  r_wgnt & ~r_w_done & m.wready;
  assign s0.bvalid  = w_wresp & ~r_wgnt & m.bvalid;
  assign s1.bvalid  = w_wresp &  r_wgnt & m.bvalid;
  assign s0.bresp   = (w_wresp & ~r_wgnt) ? m.bresp : '0;
  assign s1.bresp   = (w_wresp &  r_wgnt) ? m.bresp : '0;

  assign s0.arready = w_rfwd & ~r_rgnt & m.arready;
  assign s1.arready = w_rfwd &  r_rgnt & m.arready;
  assign s0.rvalid  = w_rdat & ~r_rgnt & m.rvalid;
  assign s1.rvalid  = w_rdat &  r_rgnt & m.rvalid;
  assign s0.rdata   = (w_rdat & ~r_rgnt) ? m.rdata : '0;
  assign s1.rdata   = (w_rdat &  r_rgnt) ? m.rdata : '0;
  assign s0.rresp   = (w_rdat & ~r_rgnt) ? m.rresp : '0;
  assign s1.rresp   = (w_rdat &  r_rgnt) ? m.rresp : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wstate  <= W_IDLE;
      r_wgnt    <= 1'b0;
      r_wr_last <= 1'b1;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      case (r_wstate)
        W_IDLE: if (s0.awvalid | s1.awvalid) begin
          r_wgnt   <= (s0.awvalid & s1.awvalid) ? ~r_wr_last : s1.awvalid;
          r_wstate <= W_FWD;
        end
        W_FWD: begin
          if ((r_aw_done | w_aw_hs) & (r_w_done | w_w_hs)) begin
            r_wstate  <= W_RESP;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
          end else begin
            if (w_aw_hs) r_aw_done <= 1'b1;
            if (w_w_hs)  r_w_done  <= 1'b1;
          end
        end
        W_RESP: if (w_b_hs) begin
          r_wr_last <= r_wgnt;
          r_wstate  <= W_IDLE;
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rstate  <= R_IDLE;
      r_rgnt    <= 1'b0;
      r_rd_last <= 1'b1;
    end else begin
      case (r_rstate)
        R_IDLE: if (s0.arvalid | s1.arvalid) begin
          r_rgnt   <= (s0.arvalid & s1.arvalid) ? ~r_rd_last : s1.arvalid;
          r_rstate <= R_FWD;
        end
        R_FWD:  if (w_ar_hs) r_rstate <= R_DATA;
        R_DATA: if (w_r_hs) begin
          r_rd_last <= r_rgnt;
          r_rstate  <= R_IDLE;
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  a_wr_idle_quiet: assert property (@(posedge clk) disable iff (rst)
    (r_wstate == W_IDLE) |-> !(w_m_awvalid || w_m_wvalid));
  a_rd_idle_quiet: assert property (@(posedge clk) disable iff (rst)
    (r_rstate == R_IDLE) |-> !w_m_arvalid);
  a_single_aw: assert property (@(posedge clk) disable iff (rst)
    w_aw_hs |-> !r_aw_done);
endmodule
